secded_decoder_pipe: RTL and testbench



---
 rtl/secded_decoder_pipe.sv | 166 ++++++++++++++++
 tb/tb_secded_decoder_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined Hamming SECDED decoder on a valid/ready stream.
// It also keeps saturating counters of accepted single-error and double-error results.
module secded_decoder_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int P = (DATA_W <= 4)  ? 3 :
                       (DATA_W <= 11) ? 4 :
                       (DATA_W <= 26) ? 5 :
                       (DATA_W <= 57) ? 6 : 7,
    localparam int CW_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              correct_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sec_err,
    output logic              ded_err,
    output logic [P-1:0]      syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    localparam int               N        = DATA_W + P;
    localparam logic [P-1:0]     N_P      = P'(N);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Hamming position of payload bit k: the k-th non-power-of-two position from 3 upward.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < 128; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [P-1:0]      syn_in;
    logic              pa_in;
    logic [DATA_W-1:0] raw_in;

    always_comb begin
        syn_in = '0;
        for (int i = 1; i <= N; i++) begin
            if (in_data[i]) syn_in = syn_in ^ P'(i);
        end
    end

    assign pa_in = ^in_data;

    // Stage 1 keeps only the slice of the codeword needed downstream: payload, s, pa.
    logic              v1_q;
    logic [DATA_W-1:0] raw1_q;
    logic [P-1:0]      syn1_q;
    logic              pa1_q;
    logic              ce1_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              sec_q;
    logic              ded_q;
    logic [P-1:0]      syn2_q;

    logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;

    logic              adv2;
    logic              adv1;
    logic              flip_en;
    logic [DATA_W-1:0] corr_d;
    logic              sec_d;
    logic              ded_d;

    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = adv2 || !v1_q;
    assign in_ready = adv1 || !rst_n;

    assign flip_en = ce1_q && pa1_q;
    assign sec_d   = pa1_q && (syn1_q <= N_P);
    assign ded_d   = (pa1_q && (syn1_q > N_P)) || (!pa1_q && (syn1_q != '0));

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_payload
        localparam int POS = data_pos(gi);
        assign raw_in[gi] = in_data[POS];
        // Only a payload position can match here, so parity-bit errors leave data untouched.
        assign corr_d[gi] = raw1_q[gi] ^ (flip_en && (syn1_q == P'(POS)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            raw1_q <= '0;
            syn1_q <= '0;
            pa1_q  <= 1'b0;
            ce1_q  <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                raw1_q <= raw_in;
                syn1_q <= syn_in;
                pa1_q  <= pa_in;
                ce1_q  <= correct_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sec_q       <= 1'b0;
            ded_q       <= 1'b0;
            syn2_q      <= '0;
        end else if (adv2) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_data_q <= corr_d;
                sec_q      <= sec_d;
                ded_q      <= ded_d;
                syn2_q     <= syn1_q;
            end
        end
    end

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (sec_q && (sec_cnt_q != CNT_MAX)) sec_cnt_d = sec_cnt_q + CNT_ONE;
            if (ded_q && (ded_cnt_q != CNT_MAX)) ded_cnt_d = ded_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sec_err   = sec_q;
    assign ded_err   = ded_q;
    assign syndrome  = syn2_q;
    assign sec_cnt   = sec_cnt_q;
    assign ded_cnt   = ded_cnt_q;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed bench for secded_decoder_pipe: a 32-bit instance with 16-bit counters
// and a second instance with 2-bit counters for the saturation and clear cases.
module tb_secded_decoder_pipe;

    logic        clk;
    logic        rst_n;
    logic [38:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        correct_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sec_err;
    logic        ded_err;
    logic [5:0]  syndrome;
    logic        cnt_clr;
    logic [15:0] sec_cnt;
    logic [15:0] ded_cnt;

    logic [38:0] s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_out_data;
    logic        s_out_valid;
    logic        s_sec_err;
    logic        s_ded_err;
    logic [5:0]  s_syndrome;
    logic        s_cnt_clr;
    logic [1:0]  s_sec_cnt;
    logic [1:0]  s_ded_cnt;

    int n_vec;
    int n_miscmp;
    int exp_sc;
    int exp_dc;

    secded_decoder_pipe #(.DATA_W(32), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .correct_en (correct_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sec_err    (sec_err),
        .ded_err    (ded_err),
        .syndrome   (syndrome),
        .cnt_clr    (cnt_clr),
        .sec_cnt    (sec_cnt),
        .ded_cnt    (ded_cnt)
    );

    secded_decoder_pipe #(.DATA_W(32), .CNT_W(2)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (s_in_data),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .correct_en (1'b1),
        .out_data   (s_out_data),
        .out_valid  (s_out_valid),
        .out_ready  (1'b1),
        .sec_err    (s_sec_err),
        .ded_err    (s_ded_err),
        .syndrome   (s_syndrome),
        .cnt_clr    (s_cnt_clr),
        .sec_cnt    (s_sec_cnt),
        .ded_cnt    (s_ded_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: payload into non-power-of-two positions, then Hamming and overall parity.
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] cw;
        logic        p;
        int          k;
        cw = '0;
        k  = 0;
        for (int i = 1; i <= 38; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 6; j++) begin
            p = 1'b0;
            for (int i = 1; i <= 38; i++) begin
                if ((((i >> j) & 1) == 1) && (i != (1 << j))) p = p ^ cw[i];
            end
            cw[1 << j] = p;
        end
        cw[0] = ^cw[38:1];
        return cw;
    endfunction

    function automatic logic [38:0] bit39(input int pos);
        logic [38:0] one;
        one = 39'd1;
        return one << pos;
    endfunction

    // One isolated word through an idle pipeline with out_ready high.
    task automatic apply_word(input string tag, input logic [38:0] cw, input logic ce,
                              input logic [31:0] e_data, input logic e_sec,
                              input logic e_ded, input logic [5:0] e_syn);
        @(posedge clk); #1;
        in_data    = cw;
        in_valid   = 1'b1;
        correct_en = ce;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        expect_eq({tag, "_valid"}, 64'(out_valid), 64'(1));
        expect_eq({tag, "_data"},  64'(out_data),  64'(e_data));
        expect_eq({tag, "_sec"},   64'(sec_err),   64'(e_sec));
        expect_eq({tag, "_ded"},   64'(ded_err),   64'(e_ded));
        expect_eq({tag, "_syn"},   64'(syndrome),  64'(e_syn));
        if (e_sec) exp_sc++;
        if (e_ded) exp_dc++;
        @(posedge clk); #1;
        expect_eq({tag, "_drain"},  64'(out_valid), 64'(0));
        expect_eq({tag, "_seccnt"}, 64'(sec_cnt),   64'(exp_sc));
        expect_eq({tag, "_dedcnt"}, 64'(ded_cnt),   64'(exp_dc));
        $display("vec %s: cw=%h ce=%0d -> data=%h sec=%0d ded=%0d syn=%0d cnt=%0d/%0d",
                 tag, cw, ce, out_data, sec_err, ded_err, syndrome, sec_cnt, ded_cnt);
    endtask

    logic [31:0] words [8];
    logic [38:0] base;

    initial begin
        int          sent;
        int          rcv;
        int          hs_unstall;
        logic        stalled_prev;
        logic        saw_not_ready;
        logic [31:0] held;

        n_vec      = 0;
        n_miscmp   = 0;
        exp_sc     = 0;
        exp_dc     = 0;
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        correct_en = 1'b1;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        s_in_data  = '0;
        s_in_valid = 1'b0;
        s_cnt_clr  = 1'b0;
        words = '{32'h0000_0001, 32'h1111_2222, 32'hCAFE_F00D, 32'h8000_0000,
                  32'hFFFF_FFFF, 32'h0BAD_C0DE, 32'h7654_3210, 32'h55AA_55AA};

        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_out_valid", 64'(out_valid), 64'(0));
        expect_eq("rst_out_data",  64'(out_data),  64'(0));
        expect_eq("rst_sec",       64'(sec_err),   64'(0));
        expect_eq("rst_ded",       64'(ded_err),   64'(0));
        expect_eq("rst_syn",       64'(syndrome),  64'(0));
        expect_eq("rst_seccnt",    64'(sec_cnt),   64'(0));
        expect_eq("rst_dedcnt",    64'(ded_cnt),   64'(0));
        expect_eq("rst_in_ready",  64'(in_ready),  64'(1));
        $display("vec reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        rst_n = 1'b1;

        base = encode(32'hDEAD_BEEF);
        apply_word("clean",    base,                          1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 6'd0);
        apply_word("sec_p3",   base ^ bit39(3),               1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 6'd3);
        apply_word("sec_raw",  base ^ bit39(3),               1'b0, 32'hDEAD_BEEE, 1'b1, 1'b0, 6'd3);
        apply_word("sec_cw0",  base ^ bit39(0),               1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 6'd0);
        apply_word("ded_3_5",  base ^ bit39(3) ^ bit39(5),    1'b1, 32'hDEAD_BEEC, 1'b0, 1'b1, 6'd6);
        apply_word("sec_par4", base ^ bit39(4),               1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 6'd4);
        apply_word("ded_sgtn", base ^ bit39(32) ^ bit39(33) ^ bit39(38),
                                                              1'b1, 32'h5AAD_BEEF, 1'b0, 1'b1, 6'd39);
        apply_word("sec_p38",  encode(32'h1234_5678) ^ bit39(38),
                                                              1'b1, 32'h1234_5678, 1'b1, 1'b0, 6'd38);

        // Stream of eight clean words with the consumer stalled for cycles 3..6.
        sent          = 0;
        rcv           = 0;
        hs_unstall    = 0;
        stalled_prev  = 1'b0;
        saw_not_ready = 1'b0;
        held          = '0;
        correct_en    = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (stalled_prev) expect_eq("stall_hold", 64'(out_data), 64'(held));
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            in_data   = encode(words[(sent < 8) ? sent : 0]);
            #1;
            if (!in_ready) saw_not_ready = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (rcv < 8) begin
                    expect_eq("stream_data", 64'(out_data), 64'(words[rcv]));
                    $display("vec stream[%0d]: cyc=%0d data=%h", rcv, cyc, out_data);
                end else begin
                    expect_eq("stream_extra", 64'(rcv), 64'(7));
                end
                if (cyc == 7 || cyc == 8) hs_unstall++;
                rcv++;
            end
            stalled_prev = out_valid && !out_ready;
            held         = out_data;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_eq("stream_count",    64'(rcv),           64'(8));
        expect_eq("stream_sent",     64'(sent),          64'(8));
        expect_eq("stream_rdy_drop", 64'(saw_not_ready), 64'(1));
        expect_eq("stream_nobubble", 64'(hs_unstall),    64'(2));
        expect_eq("stream_idle",     64'(out_valid),     64'(0));
        expect_eq("stream_seccnt",   64'(sec_cnt),       64'(exp_sc));

        // Two-bit counters: saturate at 3, then clear wins over the sixth increment.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            s_in_data  = encode(32'hA5A5_0001 + 32'(i)) ^ bit39(7);
            s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            @(posedge clk); #1;
            expect_eq("sat_sec", 64'(s_sec_err),  64'(1));
            expect_eq("sat_syn", 64'(s_syndrome), 64'(7));
            if (i == 5) s_cnt_clr = 1'b1;
            @(posedge clk); #1;
            s_cnt_clr = 1'b0;
            expect_eq("sat_cnt", 64'(s_sec_cnt), 64'((i < 5) ? ((i + 1 > 3) ? 3 : i + 1) : 0));
            $display("vec sat[%0d]: sec_cnt=%0d", i, s_sec_cnt);
        end

        // Reset with two single-error words in flight.
        expect_eq("pre_rst_seccnt", 64'(sec_cnt), 64'(exp_sc));
        @(posedge clk); #1;
        in_data  = encode(32'h0F0F_0F0F) ^ bit39(3);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_data  = encode(32'hF0F0_F0F0) ^ bit39(5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        expect_eq("mid_rst_valid",  64'(out_valid), 64'(0));
        expect_eq("mid_rst_seccnt", 64'(sec_cnt),   64'(0));
        expect_eq("mid_rst_dedcnt", 64'(ded_cnt),   64'(0));
        expect_eq("mid_rst_ready",  64'(in_ready),  64'(1));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            expect_eq("post_rst_stale", 64'(out_valid), 64'(0));
        end
        expect_eq("post_rst_seccnt", 64'(sec_cnt), 64'(0));
        $display("vec midreset: out_valid=%0d sec_cnt=%0d ded_cnt=%0d", out_valid, sec_cnt, ded_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
